// File: rtl/spi_tx_serializer.sv
// SPI transmit serializer: one-deep pending buffer feeding a shifter that drives
// a framed serial line (en_out), a divided serial clock (clk_out) and data (out).
module spi_tx_serializer #(
  parameter int DATA_W    = 8,
  parameter int CLK_DIV   = 2,
  parameter int MSB_FIRST = 0,
  parameter int CPOL      = 0,
  parameter int GAP       = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              out,
  output logic              en_out,
  output logic              clk_out,
  output logic              busy,
  output logic              done,
  output logic [1:0]        dbg_state
);

  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP - 1);
  localparam logic          CPOL_L   = (CPOL != 0);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;

  logic [1:0]        r_state;
  logic [DATA_W-1:0] r_pend_data;
  logic              r_pend_valid;
  logic [DATA_W-1:0] r_shift;
  logic [BW-1:0]     r_bit_cnt;
  logic [DW-1:0]     r_div_cnt;
  logic              r_half;
  logic [GW-1:0]     r_gap_cnt;
  logic              r_clk_out;
  logic              r_done;

  logic [1:0]        w_state_nxt;
  logic              w_accept;
  logic              w_load;
  logic              w_div_wrap;
  logic              w_bit_last;
  logic              w_gap_last;
  logic              w_frame_end;
  logic              w_cur_bit;
  logic [DATA_W-1:0] w_shift_nxt;

  // Handshake: a word transfers on a rising edge where in_valid && in_ready;
  // in_ready depends only on the pending register and rst, never on in_valid.
  assign in_ready   = !r_pend_valid && !rst;
  assign w_accept   = in_valid && in_ready;

  assign w_div_wrap  = (r_div_cnt == DIV_LAST);
  assign w_bit_last  = (r_bit_cnt == BIT_LAST);
  assign w_gap_last  = (r_gap_cnt == GAP_LAST);
  assign w_load      = r_pend_valid &&
                       ((r_state == S_IDLE) || ((r_state == S_GAP) && w_gap_last));
  assign w_frame_end = (r_state == S_SHIFT) && w_div_wrap && r_half && w_bit_last;

  always_comb begin
    w_cur_bit   = r_shift[0];
    w_shift_nxt = {1'b0, r_shift[DATA_W-1:1]};
    if (MSB_FIRST != 0) begin
      w_cur_bit   = r_shift[DATA_W-1];
      w_shift_nxt = {r_shift[DATA_W-2:0], 1'b0};
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (r_pend_valid) w_state_nxt = S_SHIFT;
      S_SHIFT: if (w_frame_end) w_state_nxt = S_GAP;
      S_GAP:   if (w_gap_last) w_state_nxt = r_pend_valid ? S_SHIFT : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Accept and load are mutually exclusive: accept needs the buffer empty, load needs it full.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend_valid <= 1'b0;
      r_pend_data  <= '0;
    end else if (w_accept) begin
      r_pend_valid <= 1'b1;
      r_pend_data  <= in_data;
    end else if (w_load) begin
      r_pend_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_div_cnt <= '0;
      r_half    <= 1'b0;
    end else if (w_load) begin
      r_shift   <= r_pend_data;
      r_bit_cnt <= '0;
      r_div_cnt <= '0;
      r_half    <= 1'b0;
    end else if (r_state == S_SHIFT) begin
      if (w_div_wrap) begin
        r_div_cnt <= '0;
        r_half    <= !r_half;
        if (r_half && !w_bit_last) begin
          r_bit_cnt <= r_bit_cnt + 1'b1;
          r_shift   <= w_shift_nxt;
        end
      end else begin
        r_div_cnt <= r_div_cnt + 1'b1;
      end
    end
  end

  // clk_out leaves CPOL at mid-bit and returns at bit end, so data is stable on the mid-bit edge.
  always_ff @(posedge clk) begin
    if (rst)                                   r_clk_out <= CPOL_L;
    else if ((r_state == S_SHIFT) && w_div_wrap) r_clk_out <= r_half ? CPOL_L : !CPOL_L;
  end

  always_ff @(posedge clk) begin
    if (rst || (r_state != S_GAP)) r_gap_cnt <= '0;
    else if (!w_gap_last)          r_gap_cnt <= r_gap_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) r_done <= 1'b0;
    else     r_done <= w_frame_end;
  end

  assign out       = (r_state == S_SHIFT) && w_cur_bit;
  assign en_out    = (r_state == S_SHIFT);
  assign clk_out   = r_clk_out;
  assign busy      = (r_state != S_IDLE) || r_pend_valid;
  assign done      = r_done;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_spi_tx_serializer.sv
// Directed bench for spi_tx_serializer: a default-parameter instance (A) and a
// 16-bit MSB-first CPOL=1 CLK_DIV=1 instance (B), with a frame monitor on A.
`timescale 1ns/1ps
module tb_spi_tx_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic [7:0]  a_data;
  logic        a_valid, a_ready, a_out, a_en, a_clk, a_busy, a_done;
  logic [1:0]  a_dbg;
  logic [15:0] b_data;
  logic        b_valid, b_ready, b_out, b_en, b_clk, b_busy, b_done;
  logic [1:0]  b_dbg;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  spi_tx_serializer #(.DATA_W(8), .CLK_DIV(2), .MSB_FIRST(0), .CPOL(0), .GAP(1)) dut_a (
    .clk(clk), .rst(rst), .in_data(a_data), .in_valid(a_valid), .in_ready(a_ready),
    .out(a_out), .en_out(a_en), .clk_out(a_clk), .busy(a_busy), .done(a_done),
    .dbg_state(a_dbg)
  );

  spi_tx_serializer #(.DATA_W(16), .CLK_DIV(1), .MSB_FIRST(1), .CPOL(1), .GAP(1)) dut_b (
    .clk(clk), .rst(rst), .in_data(b_data), .in_valid(b_valid), .in_ready(b_ready),
    .out(b_out), .en_out(b_en), .clk_out(b_clk), .busy(b_busy), .done(b_done),
    .dbg_state(b_dbg)
  );

  // Expected per-frame out patterns for A: each data bit expanded to 4 cycles.
  logic [31:0] exp_q[$];

  // Frame monitor for A, sampled on the falling edge.
  logic        a_prev_en = 1'b0;
  int          a_k = 0;
  int          a_low = 0;
  logic [31:0] a_ov, a_cv;
  logic [31:0] mon_out_q[$], mon_clk_q[$];
  int          mon_len_q[$], mon_start_q[$], mon_gap_q[$];
  logic        mon_done_q[$];
  int          a_done_cnt = 0;
  int          a_idle_bad = 0;

  always @(negedge clk) begin
    cyc++;
    if (a_en === 1'b1) begin
      if (a_prev_en !== 1'b1) begin
        a_k = 0;
        a_ov = '0;
        a_cv = '0;
        mon_start_q.push_back(cyc);
        mon_gap_q.push_back(a_low);
      end
      if (a_k < 32) begin
        a_ov[a_k[4:0]] = a_out;
        a_cv[a_k[4:0]] = a_clk;
      end
      a_k++;
      a_low = 0;
    end else begin
      a_low++;
      if (a_out === 1'b1 || a_clk === 1'b1) a_idle_bad++;
      if (a_prev_en === 1'b1) begin
        mon_out_q.push_back(a_ov);
        mon_clk_q.push_back(a_cv);
        mon_len_q.push_back(a_k);
        mon_done_q.push_back(a_done);
      end
    end
    if (a_done === 1'b1) a_done_cnt++;
    a_prev_en = a_en;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic send_a(input logic [7:0] d, output int waits);
    waits = 0;
    a_valid = 1'b1;
    a_data = d;
    while (!a_ready && waits < 200) begin
      tick();
      waits++;
    end
    if (waits >= 200) check_eq("send_a ready timeout", 32'(a_ready), 32'd1);
    else tick();
    a_valid = 1'b0;
    a_data = 8'($urandom);
  endtask

  task automatic send_b(input logic [15:0] d, output int waits);
    waits = 0;
    b_valid = 1'b1;
    b_data = d;
    while (!b_ready && waits < 200) begin
      tick();
      waits++;
    end
    if (waits >= 200) check_eq("send_b ready timeout", 32'(b_ready), 32'd1);
    else tick();
    b_valid = 1'b0;
    b_data = 16'($urandom);
  endtask

  task automatic wait_frames(input int n);
    int t = 0;
    while (mon_out_q.size() < n && t < 400) begin
      tick();
      t++;
    end
    check_eq("frames seen", 32'(mon_out_q.size()), 32'(n));
  endtask

  task automatic check_frame(input string tag);
    logic [31:0] e;
    if (mon_out_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_eq({tag, " out"}, mon_out_q.pop_front(), e);
      check_eq({tag, " clk_out"}, mon_clk_q.pop_front(), 32'hCCCC_CCCC);
      check_eq({tag, " en_out len"}, 32'(mon_len_q.pop_front()), 32'd32);
      check_eq({tag, " done at end"}, 32'(mon_done_q.pop_front()), 32'd1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int sz;
    int dc;
    logic [31:0] ov, cv, ev;

    rst = 1'b1;
    a_valid = 1'b0; a_data = '0;
    b_valid = 1'b0; b_data = '0;
    repeat (3) tick();
    check_eq("ready during reset", 32'({a_ready, b_ready}), 32'd0);
    rst = 1'b0;
    #1;
    check_eq("reset state A", 32'({a_out, a_en, a_clk, a_done, a_busy, a_ready, a_dbg}), 32'b0000_0100);
    check_eq("reset state B", 32'({b_out, b_en, b_clk, b_done, b_busy, b_ready}), 32'b00_1001);

    // Idle quiescence
    for (int i = 0; i < 100; i++) begin
      tick();
      check_eq("idle quiet", 32'({a_out, a_en, a_done, a_clk, a_ready}), 32'b0_0001);
    end

    // Single frame 0xB4, LSB first, 4 cycles per bit
    send_a(8'hB4, w);
    exp_q.push_back(32'hF0FF_0F00);
    check_eq("b4 accept wait", 32'(w), 32'd0);
    check_eq("b4 after accept en/ready/busy", 32'({a_en, a_ready, a_busy}), 32'b001);
    tick();
    check_eq("b4 start en/out/ready", 32'({a_en, a_out, a_ready}), 32'b101);
    wait_frames(1);
    check_frame("b4");
    check_eq("b4 done count", 32'(a_done_cnt), 32'd1);
    tick();
    check_eq("b4 idle busy", 32'({a_busy, a_en}), 32'd0);

    // Back-to-back with backpressure: 0x3C, 0xC3, 0x55
    mon_start_q.delete();
    mon_gap_q.delete();
    send_a(8'h3C, w);
    exp_q.push_back(32'h00FF_FF00);
    check_eq("3c accept wait", 32'(w), 32'd0);
    send_a(8'hC3, w);
    exp_q.push_back(32'hFF00_00FF);
    check_eq("c3 accept wait", 32'(w), 32'd1);
    send_a(8'h55, w);
    exp_q.push_back(32'h0F0F_0F0F);
    check_eq("55 backpressure wait", 32'(w), 32'd32);
    wait_frames(3);
    check_frame("3c");
    check_frame("c3");
    check_frame("55");
    check_eq("b2b frame count", 32'(mon_start_q.size()), 32'd3);
    if (mon_start_q.size() == 3 && mon_gap_q.size() == 3) begin
      check_eq("start-to-start 1", 32'(mon_start_q[1] - mon_start_q[0]), 32'd33);
      check_eq("start-to-start 2", 32'(mon_start_q[2] - mon_start_q[1]), 32'd33);
      check_eq("gap 1", 32'(mon_gap_q[1]), 32'd1);
      check_eq("gap 2", 32'(mon_gap_q[2]), 32'd1);
    end
    check_eq("b2b done count", 32'(a_done_cnt), 32'd4);

    // Reset during bit 3 of 0xFF with 0x0F pending
    send_a(8'hFF, w);
    send_a(8'h0F, w);
    check_eq("0f accept wait", 32'(w), 32'd1);
    repeat (12) tick();
    check_eq("ff bit3 en/out/busy", 32'({a_en, a_out, a_busy}), 32'b111);
    sz = mon_start_q.size();
    dc = a_done_cnt;
    rst = 1'b1;
    tick();
    check_eq("mid-frame reset outs", 32'({a_out, a_en, a_clk, a_busy, a_done, a_ready}), 32'd0);
    rst = 1'b0;
    #1;
    check_eq("ready after reset", 32'(a_ready), 32'd1);
    repeat (60) tick();
    check_eq("no frame after reset", 32'(mon_start_q.size()), 32'(sz));
    check_eq("no done after reset", 32'(a_done_cnt), 32'(dc));
    check_eq("idle after reset", 32'({a_busy, a_en, a_out}), 32'd0);
    mon_out_q.delete(); mon_clk_q.delete(); mon_len_q.delete(); mon_done_q.delete();

    // Recovery with a fresh word 0xA5
    send_a(8'hA5, w);
    exp_q.push_back(32'hF0F0_0F0F);
    wait_frames(1);
    check_frame("a5");
    check_eq("idle out/clk_out violations", 32'(a_idle_bad), 32'd0);

    // Instance B: 0x8001, MSB first, 2 cycles per bit, clk_out idles high
    send_b(16'h8001, w);
    check_eq("8001 accept wait", 32'(w), 32'd0);
    tick();
    ov = '0; cv = '0; ev = '0;
    for (int k = 0; k < 32; k++) begin
      ov[k[4:0]] = b_out;
      cv[k[4:0]] = b_clk;
      ev[k[4:0]] = b_en;
      tick();
    end
    check_eq("8001 out", ov, 32'hC000_0003);
    check_eq("8001 clk_out", cv, 32'h5555_5555);
    check_eq("8001 en_out", ev, 32'hFFFF_FFFF);
    check_eq("8001 end en/done/clk", 32'({b_en, b_done, b_clk}), 32'b011);
    tick();
    check_eq("8001 after done/clk/busy", 32'({b_done, b_clk, b_busy}), 32'b010);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/spi_tx_serializer.md
# spi_tx_serializer

Parametrised SPI transmit serializer that replaces the fixed 8-bit output shifter at the hash-table output. It accepts words over a valid/ready handshake and buffers one pending word so frames can run back-to-back. Each word is shifted out on a single data line with a chip-enable and a divided serial clock. Width, bit order, clock rate, clock polarity and inter-frame gap are set by parameters.

## Interface
- DATA_W, 8: bits per frame (≥2)
- CLK_DIV, 2: `clk` cycles per serial-clock half-period (≥1)
- MSB_FIRST, 0: 0 = bit 0 shifted first, 1 = bit DATA_W-1 first
- CPOL, 0: idle level of `clk_out`
- GAP, 1: `clk` cycles `en_out` stays low between frames (≥1)

Ports:
- clk  in  1  system clock; all logic is on the rising edge
- rst  in  1  reset, synchronous and active-high
- in_data  in  DATA_W  word to transmit; captured on handshake
- in_valid  in  1  `in_data` is valid
- in_ready  out  1  pending buffer empty; equals !pend_valid && !rst
- out  out  1  serial data; 0 whenever `en_out` = 0
- en_out  out  1  high for exactly the frame duration
- clk_out  out  1  serial clock; CPOL when not shifting
- busy  out  1  state != IDLE or pend_valid
- done  out  1  one-cycle pulse at frame end

## Operation
- Handshake: a word is accepted at a rising edge where in_valid && in_ready. It goes into the pending register (pend_data, pend_valid=1). `in_data` is a don't-care at all other times.
- States:
  - IDLE: if pend_valid, load the shifter from pend_data, clear pend_valid, set bit_cnt=0 and div_cnt=0, go to SHIFT.
  - SHIFT: div_cnt counts 0..CLK_DIV-1.
    - When div_cnt wraps during the first half-period, toggle `clk_out` to !CPOL.
    - When it wraps during the second half-period, restore `clk_out` to CPOL and advance the shifter to the next bit.
    - After bit DATA_W-1 completes its second half-period, drop `en_out`, pulse `done`, and go to GAP.
  - GAP: count GAP cycles. On the last gap cycle, if pend_valid, load and go to SHIFT directly. Otherwise go to IDLE.
- Output levels:
  - `out` presents the current bit for a full 2×CLK_DIV cycles, so the data is stable across the mid-bit `clk_out` edge (mode 0 when CPOL=0).
  - `en_out` = 1 exactly while in SHIFT.
- Pending buffer:
  - A word may be accepted during SHIFT or GAP (one deep).
  - A same-cycle accept and load in IDLE is not possible: the buffer is written at edge T and read at edge T+1.
- Counters:
  - bit_cnt is ceil(log2(DATA_W)) bits wide.
  - div_cnt is ceil(log2(CLK_DIV)) bits wide, minimum 1.
  - Neither counter wraps outside SHIFT.
- Reset (any cycle, including mid-frame):
  - Next-edge values: state=IDLE, pend_valid=0, out=0, en_out=0, clk_out=CPOL, done=0, busy=0.
  - The in-flight frame and the pending word are discarded, with no `done` pulse.
  - `in_ready` is 0 while `rst`=1 and 1 in the first cycle after.

## Timing
- Latency from accept to start:
  - Accept at edge T0 with the block in IDLE.
  - `en_out`=1 and the first bit are on `out` after edge T0+1.
- Frame length: `en_out` high for exactly DATA_W×2×CLK_DIV cycles. `clk_out` produces DATA_W full periods.
- `done`: high for one cycle, coincident with the first cycle `en_out`=0.
- Back-to-back throughput (pending word present before the gap ends):
  - Frame start-to-start is DATA_W×2×CLK_DIV+GAP cycles.
  - `en_out` is low for exactly GAP cycles between frames.
- Idle restart: a frame started from IDLE begins one cycle after the word lands in the buffer.
- Backpressure: `in_ready`=0 from the accept edge until the edge that loads the shifter. It reads 1 in the cycle after the load.

## Test plan
- Single frame, defaults:
  - Stimulus: 0xB4 (1011_0100) accepted from IDLE.
  - `out` (LSB first) = 0,0,1,0,1,1,0,1, each held 4 cycles.
  - `en_out` high for 32 cycles; `clk_out` shows 8 rising edges mid-bit; one `done` pulse.
- MSB_FIRST=1, DATA_W=16, CLK_DIV=1, CPOL=1:
  - Stimulus: 0x8001.
  - `out` = 1, then fourteen 0s, then 1, each held 2 cycles.
  - `clk_out` idles high and falls at each bit midpoint; `en_out` high for 32 cycles.
- Back-to-back, defaults:
  - Stimulus: 0x3C, then 0xC3 offered during the first frame.
  - 0xC3 is accepted immediately; `en_out` is low for exactly 1 cycle between frames.
  - Start-to-start = 33 cycles; two `done` pulses.
- Backpressure:
  - Stimulus: a third word 0x55 held valid while 0xC3 is pending.
  - `in_ready`=0 until 0xC3 loads, then 0x55 is accepted.
  - No word is lost or duplicated; the serial stream is 0x3C, 0xC3, 0x55.
- Reset mid-frame:
  - Stimulus: `rst` asserted for 1 cycle during bit 3 of 0xFF, with 0x0F pending.
  - After the next edge: `out`=0, `en_out`=0, `clk_out`=CPOL, `busy`=0, no `done`.
  - Nothing is transmitted afterward until a new accept.
- Idle quiescence:
  - Stimulus: `in_valid`=0 for 100 cycles after reset.
  - `out`, `en_out` and `done` stay at 0, `clk_out` stays at CPOL, and `in_ready` stays at 1.
